axi256_burst_responder: RTL and testbench

- Memory-side responder for the 256-bit burst interface that the accelerator's DMA engines drive as initiators.
- Services INCR read bursts (AR/R) and write bursts (AW/W/B) from an internal byte-enabled word array.
- Used as the on-chip scratch SRAM behind the accelerator and as the memory model in accelerator-level benches.
- Read and write channels run independent FSMs and may be active at the same time.

---
 rtl/axi256_burst_responder_if.sv | 45 ++++
 rtl/axi256_burst_responder.sv | 206 ++++++++++++++++++++
 tb/tb_axi256_burst_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi256_burst_responder_if.sv
// Bus bundle for the 256-bit burst responder: AW/W/B write channels and
// AR/R read channels. The initiator drives the master side; the memory
// responder sits on the slave side.
interface axi256_burst_responder_if #(
  parameter int ADDR_W = 32
);
  // Write address channel
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic              awvalid;
  logic              awready;
  // Write data channel
  logic [255:0]      wdata;
  logic [31:0]       wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  // Write response channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // Read address channel
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic              arvalid;
  logic              arready;
  // Read data channel
  logic [255:0]      rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi256_burst_responder.sv
// Memory-side responder for 256-bit INCR bursts. Independent read and write
// FSMs share one byte-enabled word array. Word addresses are carried one bit
// wider than the byte address so base + beat never wraps and out-of-range
// beats are detected reliably (reads return zero/SLVERR, writes are dropped).
module axi256_burst_responder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  axi256_burst_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WA_W  = ADDR_W + 1;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [255:0] mem [DEPTH];

  logic init_done_q;

  // Read-side registers
  r_state_t         r_state_q, r_state_d;
  logic [WA_W-1:0]  r_word_q, r_word_d;
  logic [3:0]       r_len_q, r_len_d;
  logic [3:0]       r_beat_q, r_beat_d;

  // Write-side registers
  w_state_t         w_state_q, w_state_d;
  logic [WA_W-1:0]  w_word_q, w_word_d;
  logic [3:0]       w_len_q, w_len_d;
  logic [3:0]       w_beat_q, w_beat_d;
  logic             w_err_q, w_err_d;

  // Combinational outputs before they are placed on the bus
  logic         arready_o, rvalid_o, rlast_o;
  logic [1:0]   rresp_o;
  logic [255:0] rdata_o;
  logic         awready_o, wready_o, bvalid_o;
  logic [1:0]   bresp_o;

  logic            mem_we;
  logic [255:0]    wr_merged;
  logic [WA_W-1:0] ar_word, aw_word;
  logic            r_oor, w_oor;
  logic [IDX_W-1:0] r_idx, w_idx;

  // Low five address bits are dropped: every burst starts on a word boundary.
  assign ar_word = {1'b0, bus.araddr} >> 5;
  assign aw_word = {1'b0, bus.awaddr} >> 5;
  assign r_oor   = (r_word_q >= WA_W'(DEPTH));
  assign w_oor   = (w_word_q >= WA_W'(DEPTH));
  assign r_idx   = r_word_q[IDX_W-1:0];
  assign w_idx   = w_word_q[IDX_W-1:0];

  // Handshake readiness is withheld for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_done_q <= 1'b0;
    else     init_done_q <= 1'b1;
  end

  // Read FSM state and burst bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_word_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_word_q  <= r_word_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
    end
  end

  // Read FSM next state and R/AR outputs; rdata reads the array at the registered index.
  always_comb begin
    r_state_d = r_state_q;
    r_word_d  = r_word_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    rresp_o   = 2'b00;
    rdata_o   = '0;
    case (r_state_q)
      R_IDLE: begin
        arready_o = init_done_q;
        if (bus.arvalid && init_done_q) begin
          r_word_d  = ar_word;
          r_len_d   = bus.arlen;
          r_beat_d  = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = (r_beat_q == r_len_q);
        if (r_oor) rresp_o = 2'b10;
        else       rdata_o = mem[r_idx];
        if (bus.rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_word_d = r_word_q + 1'b1;
            r_beat_d = r_beat_q + 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM state, burst bookkeeping and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_word_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_word_q  <= w_word_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
    end
  end

  // Write FSM next state, AW/W/B outputs and array write enable.
  always_comb begin
    w_state_d = w_state_q;
    w_word_d  = w_word_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bresp_o   = 2'b00;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_o = init_done_q;
        if (bus.awvalid && init_done_q) begin
          w_word_d  = aw_word;
          w_len_d   = bus.awlen;
          w_beat_d  = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (bus.wvalid) begin
          if (w_oor) w_err_d = 1'b1;
          else       mem_we  = 1'b1;
          // A misplaced wlast is flagged but never ends the burst early.
          if (bus.wlast != (w_beat_q == w_len_q)) w_err_d = 1'b1;
          if (w_beat_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_word_d = w_word_q + 1'b1;
            w_beat_d = w_beat_q + 1'b1;
          end
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        bresp_o  = w_err_q ? 2'b10 : 2'b00;
        if (bus.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Byte-lane merge of new data over the currently stored word.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_lane
      assign wr_merged[8*gi +: 8] = bus.wstrb[gi] ? bus.wdata[8*gi +: 8]
                                                  : mem[w_idx][8*gi +: 8];
    end
  endgenerate

  // Array write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_idx] <= wr_merged;
  end

  assign bus.arready = arready_o;
  assign bus.rvalid  = rvalid_o;
  assign bus.rlast   = rlast_o;
  assign bus.rresp   = rresp_o;
  assign bus.rdata   = rdata_o;
  assign bus.awready = awready_o;
  assign bus.wready  = wready_o;
  assign bus.bvalid  = bvalid_o;
  assign bus.bresp   = bresp_o;

endmodule

// File: tb/tb_axi256_burst_responder.sv
// Randomised bench for axi256_burst_responder against a byte-level memory model.
module tb_axi256_burst_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi256_burst_responder_if #(.ADDR_W(32)) bus();

  axi256_burst_responder #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference memory: word contents plus which bytes have ever been written.
  logic [255:0] model_mem   [256];
  logic [31:0]  model_known [256];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] strb_mask(input logic [31:0] s);
    logic [255:0] m;
    for (int i = 0; i < 32; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [255:0] data [16], input logic [31:0] strb [16],
                          input int last_beat, input string tag);
    int n;
    logic exp_err;
    logic [63:0] w;
    logic [255:0] m;
    exp_err = 1'b0;
    @(negedge clk);
    bus.awaddr = addr; bus.awlen = 4'(len); bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_awready"}, 256'(bus.awready), 256'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.wdata = data[b]; bus.wstrb = strb[b];
      bus.wlast = (b == last_beat); bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      check({tag, "_wready"}, 256'(bus.wready), 256'd1);
      w = {32'd0, addr} / 64'd32 + 64'(b);
      if (w >= 64'd256) begin
        exp_err = 1'b1;
      end else begin
        m = strb_mask(strb[b]);
        model_mem[w[7:0]]   = (model_mem[w[7:0]] & ~m) | (data[b] & m);
        model_known[w[7:0]] = model_known[w[7:0]] | strb[b];
      end
      if ((b == last_beat) != (b == len)) exp_err = 1'b1;
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check({tag, "_bvalid"}, 256'(bus.bvalid), 256'd1);
    check({tag, "_bresp"}, 256'(bus.bresp), exp_err ? 256'd2 : 256'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check({tag, "_bdone"}, 256'(bus.bvalid), 256'd0);
    $display("[TB] write %s addr=%h len=%0d bresp=%0d", tag, addr, len, bus.bresp);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [31:0] rr_pat, input string tag);
    int n, beat, cyc;
    logic [63:0] w;
    logic [255:0] m;
    @(negedge clk);
    bus.araddr = addr; bus.arlen = 4'(len); bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_arready"}, 256'(bus.arready), 256'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 200) begin
      bus.rready = (cyc < 32) ? rr_pat[cyc] : 1'b1;
      check({tag, "_rvalid"}, 256'(bus.rvalid), 256'd1);
      check({tag, "_ar_busy"}, 256'(bus.arready), 256'd0);
      check({tag, "_rlast"}, 256'(bus.rlast), 256'(beat == len));
      w = {32'd0, addr} / 64'd32 + 64'(beat);
      if (w >= 64'd256) begin
        check({tag, "_rresp_oor"}, 256'(bus.rresp), 256'd2);
        check({tag, "_rdata_oor"}, bus.rdata, 256'd0);
      end else begin
        m = strb_mask(model_known[w[7:0]]);
        check({tag, "_rresp"}, 256'(bus.rresp), 256'd0);
        check({tag, "_rdata"}, bus.rdata & m, model_mem[w[7:0]] & m);
      end
      @(negedge clk);
      if (bus.rready) beat++;
      cyc++;
    end
    bus.rready = 1'b0;
    check({tag, "_rdone"}, 256'(bus.rvalid), 256'd0);
    check({tag, "_ar_free"}, 256'(bus.arready), 256'd1);
    $display("[TB] read %s addr=%h len=%0d cycles=%0d", tag, addr, len, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] d [16];
    logic [31:0]  s [16];
    logic [31:0]  a;
    int ln;
    for (int i = 0; i < 256; i++) begin model_mem[i] = '0; model_known[i] = '0; end
    for (int i = 0; i < 16; i++) begin d[i] = '0; s[i] = '1; end
    rst = 1'b1;
    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state and init_done delay
    repeat (3) @(negedge clk);
    check("rst_awready", 256'(bus.awready), 256'd0);
    check("rst_arready", 256'(bus.arready), 256'd0);
    check("rst_bvalid", 256'(bus.bvalid), 256'd0);
    check("rst_rvalid", 256'(bus.rvalid), 256'd0);
    rst = 1'b0;
    #1;
    check("init_awready0", 256'(bus.awready), 256'd0);
    check("init_arready0", 256'(bus.arready), 256'd0);
    @(negedge clk);
    check("init_awready1", 256'(bus.awready), 256'd1);
    check("init_arready1", 256'(bus.arready), 256'd1);
    check("init_wready", 256'(bus.wready), 256'd0);
    $display("[TB] reset release checked");

    // Basic two-beat write and read back
    d[0] = {32{8'h11}}; d[1] = {32{8'h22}};
    do_write(32'h40, 1, d, s, 1, "wr40");
    do_read(32'h40, 1, 32'hFFFF_FFFF, "rd40");

    // Partial strobe over a zeroed word
    d[0] = '0;
    do_write(32'h60, 0, d, s, 0, "zero3");
    d[0] = 256'hDEADBEEF; s[0] = 32'h0000_000F;
    do_write(32'h60, 0, d, s, 0, "part3");
    s[0] = '1;
    do_read(32'h60, 0, 32'hFFFF_FFFF, "rdpart");

    // Backpressure on a four-beat read: rready 1,0,0,1 then high
    for (int i = 0; i < 4; i++) d[i] = {8{$urandom}};
    do_write(32'h100, 3, d, s, 3, "wr4");
    do_read(32'h100, 3, 32'hFFFF_FFF9, "rdbp");

    // Top-of-array boundary: second beat falls outside
    d[0] = {8{$urandom}};
    do_write(32'h1FE0, 0, d, s, 0, "wrtop");
    do_read(32'h1FE0, 1, 32'hFFFF_FFFF, "rdoor");
    d[0] = {8{$urandom}}; d[1] = {8{$urandom}};
    do_write(32'h1FE0, 1, d, s, 1, "wroor");
    do_read(32'h1FE0, 0, 32'hFFFF_FFFF, "rdtop");

    // Early wlast: both beats still written, SLVERR reported
    d[0] = {8{$urandom}}; d[1] = {8{$urandom}};
    do_write(32'h200, 1, d, s, 0, "wrlast");
    do_read(32'h200, 1, 32'hFFFF_FFFF, "rdlast");

    // Randomised bursts with random strobes and random rready
    for (int it = 0; it < 10; it++) begin
      a  = 32'($urandom_range(0, 250)) * 32 + 32'($urandom_range(0, 31));
      ln = $urandom_range(0, 3);
      for (int b = 0; b < 16; b++) begin
        d[b] = {8{$urandom}};
        s[b] = (it % 2 == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      do_write(a, ln, d, s, ln, "wrrnd");
      do_read(a, ln, $urandom, "rdrnd");
    end
    for (int b = 0; b < 16; b++) s[b] = '1;

    // Concurrent read and write on different words
    d[0] = {8{$urandom}}; d[1] = {8{$urandom}};
    fork
      do_write(32'h400, 1, d, s, 1, "wrcc");
      do_read(32'h40, 1, $urandom, "rdcc");
    join
    do_read(32'h400, 1, 32'hFFFF_FFFF, "rdcc2");

    // Reset during the first data beat of a write
    @(negedge clk);
    bus.awaddr = 32'h600; bus.awlen = 4'd1; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wdata = {8{$urandom}}; bus.wstrb = '1; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    check("abort_wready", 256'(bus.wready), 256'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_wready0", 256'(bus.wready), 256'd0);
    check("abort_awready0", 256'(bus.awready), 256'd0);
    check("abort_arready0", 256'(bus.arready), 256'd0);
    check("abort_bvalid0", 256'(bus.bvalid), 256'd0);
    check("abort_rvalid0", 256'(bus.rvalid), 256'd0);
    bus.wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_nob", 256'(bus.bvalid), 256'd0);
    $display("[TB] reset mid-burst checked");
    do_read(32'h40, 1, 32'hFFFF_FFFF, "rdkeep1");
    do_read(32'h400, 1, 32'hFFFF_FFFF, "rdkeep2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
